slink_flit_layer: RTL and testbench



---
 rtl/slink_pkg.sv | 11 +
 rtl/slink_flit_layer.sv | 186 ++++++++++++++++++
 tb/tb_slink_flit_layer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slink_pkg.sv
// Shared constants for the serial-link flit layer: default flit width and the
// layout of the per-flit header that travels alongside the flit data.
package slink_pkg;

  localparam int unsigned DefaultFlitWidth = 16;

  // The header is a sideband field next to the data; bit 0 marks the final flit of a payload.
  localparam int unsigned FlitHdrWidth = 1;
  localparam int unsigned FlitLastBit  = 0;

endpackage

// File: rtl/slink_flit_layer.sv
// Flit layer: splits AXIS payloads into link flits on TX and reassembles
// flits into payloads on RX, flagging framing errors on the receive side.
module slink_flit_layer
  import slink_pkg::*;
#(
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned FlitWidth    = DefaultFlitWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    axis_in_valid_i,
  output logic                    axis_in_ready_o,
  input  logic [PayloadWidth-1:0] axis_in_data_i,
  output logic                    flit_out_valid_o,
  input  logic                    flit_out_ready_i,
  output logic [FlitWidth-1:0]    flit_out_data_o,
  output logic                    flit_out_last_o,
  input  logic                    flit_in_valid_i,
  output logic                    flit_in_ready_o,
  input  logic [FlitWidth-1:0]    flit_in_data_i,
  input  logic                    flit_in_last_i,
  output logic                    axis_out_valid_o,
  input  logic                    axis_out_ready_i,
  output logic [PayloadWidth-1:0] axis_out_data_o,
  output logic                    rx_err_o
);

  localparam int unsigned NumFlits = (PayloadWidth + FlitWidth - 1) / FlitWidth;
  localparam int unsigned BufWidth = NumFlits * FlitWidth;
  localparam int unsigned IdxWidth = (NumFlits > 1) ? $clog2(NumFlits) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumFlits - 1);

  typedef enum logic {TxIdle, TxSend} tx_state_e;
  typedef enum logic [1:0] {RxCollect, RxFull, RxDrop} rx_state_e;

  tx_state_e            tx_state, tx_state_next;
  logic [IdxWidth-1:0]  tx_idx, tx_idx_next;
  logic [FlitWidth-1:0] tx_slots [NumFlits];
  logic [BufWidth-1:0]  tx_pad;
  logic                 tx_at_last, in_fire, flit_out_fire;
  logic [FlitHdrWidth-1:0] tx_hdr;

  always_comb begin
    tx_pad = '0;
    tx_pad[PayloadWidth-1:0] = axis_in_data_i;
  end

  assign tx_at_last       = (tx_idx == LastIdx);
  assign flit_out_valid_o = (tx_state == TxSend);
  assign flit_out_fire    = flit_out_valid_o && flit_out_ready_i;
  assign axis_in_ready_o  = (tx_state == TxIdle) || (flit_out_fire && tx_at_last);
  assign in_fire          = axis_in_valid_i && axis_in_ready_o;
  assign flit_out_data_o  = tx_slots[tx_idx];

  always_comb begin
    tx_hdr = '0;
    tx_hdr[FlitLastBit] = flit_out_valid_o && tx_at_last;
  end
  assign flit_out_last_o = tx_hdr[FlitLastBit];

  always_comb begin
    tx_state_next = tx_state;
    tx_idx_next   = tx_idx;
    case (tx_state)
      TxIdle: begin
        if (in_fire) begin
          tx_state_next = TxSend;
          tx_idx_next   = '0;
        end
      end
      TxSend: begin
        if (flit_out_fire) begin
          if (!tx_at_last) begin
            tx_idx_next = tx_idx + 1'b1;
          end else begin
            // A new payload accepted on the last flit keeps the link busy with no bubble.
            tx_state_next = in_fire ? TxSend : TxIdle;
            tx_idx_next   = '0;
          end
        end
      end
      default: tx_state_next = TxIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state <= TxIdle;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_state_next;
      tx_idx   <= tx_idx_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      for (int i = 0; i < NumFlits; i++) begin
        tx_slots[i] <= tx_pad[i*FlitWidth +: FlitWidth];
      end
    end
  end

  rx_state_e            rx_state, rx_state_next;
  logic [IdxWidth-1:0]  rx_idx, rx_idx_next, rx_slot;
  logic [FlitWidth-1:0] rx_slots [NumFlits];
  logic [BufWidth-1:0]  rx_flat;
  logic [FlitHdrWidth-1:0] rx_hdr;
  logic                 rx_last, rx_accept, rx_err_next;

  assign rx_hdr  = FlitHdrWidth'(flit_in_last_i);
  assign rx_last = rx_hdr[FlitLastBit];

  always_comb begin
    rx_state_next    = rx_state;
    rx_idx_next      = rx_idx;
    rx_err_next      = 1'b0;
    rx_accept        = 1'b0;
    rx_slot          = rx_idx;
    flit_in_ready_o  = 1'b1;
    axis_out_valid_o = 1'b0;
    case (rx_state)
      RxCollect: rx_accept = flit_in_valid_i;
      RxFull: begin
        axis_out_valid_o = 1'b1;
        flit_in_ready_o  = axis_out_ready_i;
        if (axis_out_ready_i) begin
          rx_state_next = RxCollect;
          rx_idx_next   = '0;
          rx_slot       = '0;
          rx_accept     = flit_in_valid_i;
        end
      end
      RxDrop: begin
        if (flit_in_valid_i && rx_last) begin
          rx_state_next = RxCollect;
        end
      end
      default: rx_state_next = RxCollect;
    endcase

    // Framing is judged against the slot the flit lands in, also for a flit taken during output.
    if (rx_accept) begin
      rx_idx_next = '0;
      if (rx_slot == LastIdx) begin
        rx_state_next = rx_last ? RxFull : RxDrop;
        rx_err_next   = !rx_last;
      end else if (rx_last) begin
        rx_state_next = RxCollect;
        rx_err_next   = 1'b1;
      end else begin
        rx_state_next = RxCollect;
        rx_idx_next   = rx_slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state <= RxCollect;
      rx_idx   <= '0;
      rx_err_o <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      rx_idx   <= rx_idx_next;
      rx_err_o <= rx_err_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_accept) begin
      rx_slots[rx_slot] <= flit_in_data_i;
    end
  end

  always_comb begin
    rx_flat = '0;
    for (int i = 0; i < NumFlits; i++) begin
      rx_flat[i*FlitWidth +: FlitWidth] = rx_slots[i];
    end
  end

  // Padding bits above the payload in the top flit are dropped here.
  assign axis_out_data_o = PayloadWidth'(rx_flat);

endmodule

// File: tb/tb_slink_flit_layer.sv
// Self-checking bench for slink_flit_layer (20-bit payloads, 8-bit flits):
// queue/frame-level reference model plus directed literal scenarios and random traffic.
module tb_slink_flit_layer;

  localparam int PW = 20;
  localparam int FW = 8;
  localparam int NF = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          axis_in_valid_i = 1'b0;
  logic          axis_in_ready_o;
  logic [PW-1:0] axis_in_data_i = '0;
  logic          flit_out_valid_o;
  logic          flit_out_ready_i = 1'b0;
  logic [FW-1:0] flit_out_data_o;
  logic          flit_out_last_o;
  logic          flit_in_valid_i = 1'b0;
  logic          flit_in_ready_o;
  logic [FW-1:0] flit_in_data_i = '0;
  logic          flit_in_last_i = 1'b0;
  logic          axis_out_valid_o;
  logic          axis_out_ready_i = 1'b0;
  logic [PW-1:0] axis_out_data_o;
  logic          rx_err_o;

  slink_flit_layer #(.PayloadWidth(PW), .FlitWidth(FW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .axis_in_valid_i(axis_in_valid_i), .axis_in_ready_o(axis_in_ready_o), .axis_in_data_i(axis_in_data_i),
    .flit_out_valid_o(flit_out_valid_o), .flit_out_ready_i(flit_out_ready_i),
    .flit_out_data_o(flit_out_data_o), .flit_out_last_o(flit_out_last_o),
    .flit_in_valid_i(flit_in_valid_i), .flit_in_ready_o(flit_in_ready_o),
    .flit_in_data_i(flit_in_data_i), .flit_in_last_i(flit_in_last_i),
    .axis_out_valid_o(axis_out_valid_o), .axis_out_ready_i(axis_out_ready_i),
    .axis_out_data_o(axis_out_data_o), .rx_err_o(rx_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pending TX flits as a queue, RX as the frame being gathered.
  logic [7:0]    txq[$];
  bit            txlq[$];
  logic [7:0]    rxFrame[$];
  bit            rxDropping = 0;
  bit            outPending = 0;
  bit            errExp = 0;
  logic [PW-1:0] outPayload = '0;

  always @(posedge clk_i) cyc++;

  always @(posedge clk_i or negedge rst_ni) begin
    bit inReady, txOutFire, inFire, rxReady, aoFire, rxFire, errNew;
    logic [23:0] pad;
    if (!rst_ni) begin
      txq.delete(); txlq.delete(); rxFrame.delete();
      rxDropping = 0; outPending = 0; errExp = 0;
    end else begin
      inReady   = (txq.size() == 0) || (txq.size() == 1 && flit_out_ready_i);
      txOutFire = (txq.size() != 0) && flit_out_ready_i;
      inFire    = axis_in_valid_i && inReady;
      if (txOutFire) begin
        void'(txq.pop_front());
        void'(txlq.pop_front());
      end
      if (inFire) begin
        pad = {4'h0, axis_in_data_i};
        for (int k = 0; k < NF; k++) begin
          txq.push_back(pad[k*8 +: 8]);
          txlq.push_back(k == NF - 1);
        end
      end
      rxReady = !outPending || axis_out_ready_i;
      aoFire  = outPending && axis_out_ready_i;
      rxFire  = flit_in_valid_i && rxReady;
      errNew  = 0;
      if (aoFire) outPending = 0;
      if (rxFire) begin
        if (rxDropping) begin
          if (flit_in_last_i) rxDropping = 0;
        end else begin
          rxFrame.push_back(flit_in_data_i);
          if (flit_in_last_i) begin
            if (rxFrame.size() == NF) begin
              outPending = 1;
              outPayload = {rxFrame[2][3:0], rxFrame[1], rxFrame[0]};
            end else begin
              errNew = 1;
            end
            rxFrame.delete();
          end else if (rxFrame.size() == NF) begin
            errNew = 1;
            rxDropping = 1;
            rxFrame.delete();
          end
        end
      end
      errExp = errNew;
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      checkOutput("axis_in_ready", axis_in_ready_o,
                  (txq.size() == 0) || (txq.size() == 1 && flit_out_ready_i));
      checkOutput("flit_out_valid", flit_out_valid_o, txq.size() != 0);
      if (txq.size() != 0) begin
        checkOutput("flit_out_data", flit_out_data_o, txq[0]);
        checkOutput("flit_out_last", flit_out_last_o, txlq[0]);
      end else begin
        checkOutput("flit_out_last_idle", flit_out_last_o, 0);
      end
      checkOutput("flit_in_ready", flit_in_ready_o, !outPending || axis_out_ready_i);
      checkOutput("axis_out_valid", axis_out_valid_o, outPending);
      if (outPending) checkOutput("axis_out_data", axis_out_data_o, outPayload);
      checkOutput("rx_err", rx_err_o, errExp);
    end
  end

  // Observation logs for the literal scenario checks.
  logic [7:0]    txLog[$];
  bit            txLastLog[$];
  int            txCyc[$];
  int            inCyc[$];
  logic [PW-1:0] rxLog[$];
  int            errCount = 0;
  bit            lastRxFire = 0;

  always @(negedge clk_i) begin
    lastRxFire = flit_in_valid_i && flit_in_ready_o;
    if (flit_out_valid_o && flit_out_ready_i) begin
      txLog.push_back(flit_out_data_o);
      txLastLog.push_back(flit_out_last_o);
      txCyc.push_back(cyc);
    end
    if (axis_in_valid_i && axis_in_ready_o) inCyc.push_back(cyc);
    if (axis_out_valid_o && axis_out_ready_i) rxLog.push_back(axis_out_data_o);
    if (rx_err_o) errCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clearLogs();
    txLog.delete(); txLastLog.delete(); txCyc.delete(); inCyc.delete();
    rxLog.delete(); errCount = 0;
  endtask

  task automatic applyStimulus(input logic [PW-1:0] payload);
    axis_in_valid_i = 1'b1;
    axis_in_data_i  = payload;
    tick(1);
    axis_in_valid_i = 1'b0;
  endtask

  task automatic sendFlit(input logic [7:0] d, input bit l);
    flit_in_valid_i = 1'b1;
    flit_in_data_i  = d;
    flit_in_last_i  = l;
    tick(1);
    flit_in_valid_i = 1'b0;
  endtask

  initial begin
    int k;
    k = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_flit_out_valid", flit_out_valid_o, 0);
    checkOutput("reset_flit_out_last", flit_out_last_o, 0);
    checkOutput("reset_axis_out_valid", axis_out_valid_o, 0);
    checkOutput("reset_rx_err", rx_err_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    flit_out_ready_i = 1'b1;
    axis_out_ready_i = 1'b1;
    tick(2);

    clearLogs();
    applyStimulus(20'hABCDE);
    tick(5);
    checkOutput("tx_single_count", txLog.size(), 3);
    checkOutput("tx_flit0", txLog[0], 8'hDE);
    checkOutput("tx_flit1", txLog[1], 8'hBC);
    checkOutput("tx_flit2", txLog[2], 8'h0A);
    checkOutput("tx_lasts", {txLastLog[0], txLastLog[1], txLastLog[2]}, 3'b001);
    checkOutput("tx_latency", txCyc[0] - inCyc[0], 1);

    clearLogs();
    axis_in_valid_i = 1'b1;
    axis_in_data_i  = 20'h11111;
    tick(1);
    axis_in_data_i  = 20'h22222;
    tick(3);
    axis_in_valid_i = 1'b0;
    tick(5);
    checkOutput("tx_b2b_count", txLog.size(), 6);
    checkOutput("tx_b2b_no_bubble", txCyc[5] - txCyc[0], 5);
    checkOutput("tx_b2b_second", txLog[3], 8'h22);

    clearLogs();
    axis_out_ready_i = 1'b0;
    sendFlit(8'h11, 0);
    sendFlit(8'h22, 0);
    sendFlit(8'h03, 1);
    flit_in_valid_i = 1'b1;
    flit_in_data_i  = 8'h44;
    flit_in_last_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput("rx_hold_ready", flit_in_ready_o, 0);
      checkOutput("rx_hold_valid", axis_out_valid_o, 1);
      @(posedge clk_i); #1;
    end
    axis_out_ready_i = 1'b1;
    tick(1);
    sendFlit(8'h55, 0);
    sendFlit(8'h06, 1);
    tick(3);
    checkOutput("rx_hold_payload", rxLog[0], 20'h32211);
    checkOutput("rx_overlap_payload", rxLog[1], 20'h65544);
    checkOutput("rx_hold_no_err", errCount, 0);

    clearLogs();
    sendFlit(8'h01, 0);
    sendFlit(8'h02, 1);
    sendFlit(8'h11, 0);
    sendFlit(8'h22, 0);
    sendFlit(8'h03, 1);
    tick(3);
    checkOutput("rx_early_errs", errCount, 1);
    checkOutput("rx_early_count", rxLog.size(), 1);
    checkOutput("rx_early_next", rxLog[0], 20'h32211);

    clearLogs();
    for (int i = 1; i <= 5; i++) sendFlit(8'(8'hA0 + i), i == 5);
    sendFlit(8'h44, 0);
    sendFlit(8'h55, 0);
    sendFlit(8'h06, 1);
    tick(3);
    checkOutput("rx_missing_errs", errCount, 1);
    checkOutput("rx_missing_count", rxLog.size(), 1);
    checkOutput("rx_missing_next", rxLog[0], 20'h65544);

    applyStimulus(20'hFEDCB);
    tick(1);
    sendFlit(8'h77, 0);
    rst_ni = 1'b0;
    tick(2);
    rst_ni = 1'b1;
    clearLogs();
    tick(3);
    checkOutput("rst_tx_idle", txLog.size(), 0);
    checkOutput("rst_rx_none", rxLog.size(), 0);
    applyStimulus(20'h12345);
    sendFlit(8'h11, 0);
    sendFlit(8'h22, 0);
    sendFlit(8'h03, 1);
    tick(4);
    checkOutput("rst_no_err", errCount, 0);
    checkOutput("rst_tx_count", txLog.size(), 3);
    checkOutput("rst_tx_flits", {txLog[0], txLog[1], txLog[2]}, 24'h452301);
    checkOutput("rst_rx_payload", rxLog[0], 20'h32211);

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk_i); #1;
      if (i == 1000) rst_ni = 1'b0;
      if (i == 1003) begin
        rst_ni = 1'b1;
        k = 0;
      end
      axis_in_valid_i  = ($urandom % 3) != 0;
      axis_in_data_i   = PW'($urandom);
      flit_out_ready_i = ($urandom % 2) != 0;
      axis_out_ready_i = ($urandom % 4) != 0;
      if (lastRxFire) begin
        k = flit_in_last_i ? 0 : k + 1;
        flit_in_data_i = 8'($urandom);
        flit_in_last_i = (($urandom % 10) == 0) ? (($urandom % 2) != 0) : (k >= NF - 1);
      end
      flit_in_valid_i = ($urandom % 4) != 0;
    end
    axis_in_valid_i = 1'b0;
    flit_in_valid_i = 1'b0;
    flit_out_ready_i = 1'b1;
    axis_out_ready_i = 1'b1;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
